// File: rtl/uart_pkg.sv
// Shared UART receive types and defaults: FSM state encoding, baud/FIFO defaults, data width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud
    localparam int unsigned DEF_FIFO_DEPTH   = 8;
    localparam int unsigned DATA_W           = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through head on rd_dat (zero while empty).
// Latency: a write is visible on rd_dat/rd_vld the cycle after the write edge.
// Backpressure: wr_rdy drops when full unless a pop happens on the same edge; rd_rdy while empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    input  logic             rd_rdy,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    // A pop on the same edge frees the slot, so a full FIFO still accepts a write then.
    assign rd_vld  = (count != '0);
    assign rd_fire = rd_rdy && rd_vld;
    assign wr_rdy  = (count != (AW+1)'(DEPTH)) || rd_fire;
    assign wr_fire = wr_vld && wr_rdy;
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    // Storage array; no reset needed since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver with 2-flop synchronizer, mid-bit sampling FSM and FWFT receive FIFO.
// Latency: byte appears on rx_data/rx_valid the cycle after the stop-bit sample edge.
// Backpressure: none on the line; a byte arriving with the FIFO full (and no pop) is dropped and flags overrun.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    input  logic                        rd,
    input  logic                        clr_err,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        overrun,
    output logic                        frame_err
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    rx_state_t         state;
    logic [15:0]       baud_cnt;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shift_dat;
    logic              baud_done;
    logic              fall;
    logic              push_vld;
    logic              push_rdy;
    logic              frame_set;
    logic              overrun_set;

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle line is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Only a real high-to-low transition starts a frame, so a line stuck low cannot retrigger.
    assign fall      = rx_prev && !rx_sync;
    assign baud_done = (state == START) ? (baud_cnt == HALF_LAST) : (baud_cnt == BAUD_LAST);

    // Push and frame error are decoded on the stop sample itself so the FIFO writes on that edge.
    assign push_vld    = (state == STOP) && baud_done && rx_sync;
    assign frame_set   = (state == STOP) && baud_done && !rx_sync;
    assign overrun_set = push_vld && !push_rdy;

    // Receive FSM: half-bit wait to centre on the start bit, then full-bit steps through data and stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_dat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fall) state <= START;
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= rx_sync ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_dat <= {rx_sync, shift_dat[DATA_W-1:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a set on the same edge as clr_err takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (overrun_set)  overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (frame_set)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (reset),
        .wr_vld (push_vld),
        .wr_dat (shift_dat),
        .wr_rdy (push_rdy),
        .rd_vld (rx_valid),
        .rd_dat (rx_data),
        .rd_rdy (rd),
        .count  (rx_count)
    );

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer at 16 clocks per bit and an 8-entry FIFO.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_rx_buffer;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [3:0] rx_count;
    logic       overrun;
    logic       frame_err;

    int pass_cnt;
    int total_cnt;

    uart_rx_buffer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd        (rd),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_bit;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
        repeat (3) tick();
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %0h expected 0", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", rx_count); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b expected 0", overrun); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %0b expected 0", frame_err); else pass_cnt++;
        reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_single();
        send_byte(8'hA5, 1'b1);
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'hA5) $display("FAIL single_data: got %0h expected a5", rx_data); else pass_cnt++;
        total_cnt++; if (rx_count !== 4'd1) $display("FAIL single_count: got %0d expected 1", rx_count); else pass_cnt++;
        pop();
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL single_pop_valid: got %0b expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (rx_count !== 4'd0) $display("FAIL single_pop_count: got %0d expected 0", rx_count); else pass_cnt++;
        // Pop on an empty FIFO must not move the pointers.
        pop();
        total_cnt++; if (rx_count !== 4'd0) $display("FAIL empty_pop_count: got %0d expected 0", rx_count); else pass_cnt++;
        send_byte(8'h5A, 1'b1);
        total_cnt++; if (rx_data !== 8'h5A) $display("FAIL empty_pop_next_data: got %0h expected 5a", rx_data); else pass_cnt++;
        total_cnt++; if (rx_count !== 4'd1) $display("FAIL empty_pop_next_count: got %0d expected 1", rx_count); else pass_cnt++;
        pop();
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b1);
        total_cnt++; if (rx_count !== 4'd8) $display("FAIL ovr_count: got %0d expected 8", rx_count); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %0b expected 1", overrun); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h01) $display("FAIL ovr_head: got %0h expected 01", rx_data); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            exp = 8'(i + 1);
            total_cnt++; if (rx_data !== exp) $display("FAIL ovr_pop%0d: got %0h expected %0h", i, rx_data, exp); else pass_cnt++;
            pop();
        end
        total_cnt++; if (rx_count !== 4'd0) $display("FAIL ovr_drain_count: got %0d expected 0", rx_count); else pass_cnt++;
        pulse_clr();
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %0b expected 0", overrun); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        send_byte(8'h3C, 1'b0);
        total_cnt++; if (frame_err !== 1'b1) $display("FAIL frame_set: got %0b expected 1", frame_err); else pass_cnt++;
        total_cnt++; if (rx_count !== 4'd0) $display("FAIL frame_count: got %0d expected 0", rx_count); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL frame_valid: got %0b expected 0", rx_valid); else pass_cnt++;
        pulse_clr();
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL frame_clear: got %0b expected 0", frame_err); else pass_cnt++;
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (3 * CPB) tick();
        total_cnt++; if (rx_count !== 4'd0) $display("FAIL glitch_count: got %0d expected 0", rx_count); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL glitch_valid: got %0b expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (dut.state !== IDLE) $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL glitch_frame_err: got %0b expected 0", frame_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h55;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = b[4];
        repeat (CPB / 2) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        rx = 1'b1;
        repeat (2 * CPB) tick();
        total_cnt++; if (rx_count !== 4'd0) $display("FAIL rstmid_empty: got %0d expected 0", rx_count); else pass_cnt++;
        send_byte(8'h81, 1'b1);
        total_cnt++; if (rx_count !== 4'd1) $display("FAIL rstmid_count: got %0d expected 1", rx_count); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h81) $display("FAIL rstmid_data: got %0h expected 81", rx_data); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL rstmid_frame_err: got %0b expected 0", frame_err); else pass_cnt++;
        pop();
    endtask

    task automatic test_full_coincident();
        logic [7:0] exp;
        logic [7:0] b;
        logic       hit;
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
        total_cnt++; if (rx_count !== 4'd8) $display("FAIL coin_fill: got %0d expected 8", rx_count); else pass_cnt++;
        // Frame 0x77 by hand so rd can be raised for exactly the push edge.
        b = 8'h77;
        hit = 1'b0;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = 1'b1;
        for (int i = 0; i < CPB + 4; i++) begin
            if (!hit && dut.push_vld) begin
                rd = 1'b1;
                hit = 1'b1;
            end
            tick();
            rd = 1'b0;
        end
        total_cnt++; if (hit !== 1'b1) $display("FAIL coin_push_seen: got %0b expected 1", hit); else pass_cnt++;
        total_cnt++; if (rx_count !== 4'd8) $display("FAIL coin_count: got %0d expected 8", rx_count); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL coin_overrun: got %0b expected 0", overrun); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            exp = (i == 7) ? 8'h77 : 8'h11 + 8'(i);
            total_cnt++; if (rx_data !== exp) $display("FAIL coin_pop%0d: got %0h expected %0h", i, rx_data, exp); else pass_cnt++;
            pop();
        end
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL coin_drained: got %0b expected 0", rx_valid); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_single();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        test_full_coincident();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, receive FIFO entries; power of two, 2..64.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rx  in  1  serial line, 8N1, idle high, asynchronous to clk.
REQ-006 rd  in  1  pop strobe from uart_device register read path; one entry per cycle high.
REQ-007 clr_err  in  1  clears sticky error flags.
REQ-008 rx_data  out  8  FIFO head byte, first-word fall-through.
REQ-009 rx_valid  out  1  FIFO not empty.
REQ-010 rx_count  out  log2(FIFO_DEPTH)+1  current occupancy.
REQ-011 overrun  out  1  sticky, byte dropped on full FIFO.
REQ-012 frame_err  out  1  sticky, stop bit sampled low.

Function
REQ-013 rx SHALL pass a 2-flop synchronizer; the FSM sees only the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE->START on synchronized high-to-low transition only; a line held low does not retrigger.
REQ-016 START: sample at CLKS_PER_BIT/2 cycles after edge; low -> DATA, high -> IDLE (glitch rejected, nothing pushed).
REQ-017 DATA: sample every CLKS_PER_BIT cycles at mid-bit, 8 bits, LSB first, 3-bit bit counter; after bit 7 -> STOP.
REQ-018 STOP: sample CLKS_PER_BIT cycles after bit 7; high -> push byte; low -> set frame_err, discard byte; both -> IDLE.
REQ-019 Pushed byte SHALL appear on rx_data/rx_valid the cycle after the stop-bit sample edge.
REQ-020 rd with rx_valid high SHALL remove the head on that edge; rd when empty SHALL be ignored with no pointer change.
REQ-021 Push with FIFO full and no rd SHALL drop the new byte, set overrun, leave contents unchanged.
REQ-022 Push and rd in the same cycle while full SHALL both succeed; count unchanged, no overrun.
REQ-023 Push and rd in the same cycle while empty SHALL push only; byte valid next cycle.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; rx_count SHALL never exceed FIFO_DEPTH.
REQ-025 clr_err clears overrun and frame_err next edge; a simultaneous set event SHALL win.

Reset
REQ-026 reset SHALL force FSM to IDLE, bit/baud counters 0, synchronizer flops to 1, pointers 0.
REQ-027 Reset output values: rx_data 0x00, rx_valid 0, rx_count 0, overrun 0, frame_err 0.
REQ-028 Reset mid-frame SHALL abandon the partial byte; the next clean start bit SHALL be received normally.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state enum, default CLKS_PER_BIT, default FIFO_DEPTH, and data width constant 8.
REQ-030 FIFO SHALL be one sub-module, sync_fifo (parameterized width/depth, FWFT); FSM/synchronizer stay in uart_rx_buffer.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=8, 10 ns clk)
REQ-031 Send 0xA5 -> rx_valid=1, rx_data=0xA5, rx_count=1; rd one cycle -> rx_valid=0, rx_count=0.
REQ-032 Send 0x01..0x09 without rd -> rx_count=8, overrun=1, rx_data=0x01; eight rd pops return 0x01..0x08.
REQ-033 Send 0x3C with stop bit low -> frame_err=1, rx_count unchanged; clr_err -> frame_err=0.
REQ-034 rx low for 4 clocks then high -> no push, FSM back in IDLE, rx_count=0.
REQ-035 Assert reset at DATA bit 4 of 0x55, then send 0x81 -> only 0x81 received, rx_count=1.
REQ-036 FIFO full, rd coincident with push of 0x77 -> rx_count=8, overrun=0, 0x77 last out.
